// File: rtl/ov_stream_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ov_stream_gen_pkg
//  Purpose  : Shared camera definitions for the OV7670-style stream source:
//             default VGA timing, FSM state encodings, pattern selectors and
//             the background / skin / colour-bar YUV constants.
//  Revision : 1.0 - initial release
// ============================================================================
package ov_stream_gen_pkg;

    // Sensor geometry and default line/frame timing (in lines / pclk cycles)
    localparam int c_CAM_WIDTH  = 640;
    localparam int c_CAM_HEIGHT = 480;
    localparam int c_H_TOTAL    = 1568;
    localparam int c_V_SYNC     = 3;
    localparam int c_V_BACK     = 17;
    localparam int c_V_FRONT    = 10;

    // Frame FSM encoding
    localparam int         c_ST_W      = 3;
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_VSYNC  = 3'd1;
    localparam logic [2:0] c_ST_VBACK  = 3'd2;
    localparam logic [2:0] c_ST_ACTIVE = 3'd3;
    localparam logic [2:0] c_ST_VFRONT = 3'd4;

    // Pattern selectors (value 0 is the flat background)
    localparam logic [1:0] c_PAT_BARS  = 2'd1;
    localparam logic [1:0] c_PAT_BLOB  = 2'd2;
    localparam logic [1:0] c_PAT_BOTH  = 2'd3;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] u;
        logic [7:0] v;
    } yuv_t;

    localparam yuv_t c_YUV_BG   = '{y: 8'h20, u: 8'h80, v: 8'h80};
    localparam yuv_t c_YUV_SKIN = '{y: 8'h80, u: 8'h70, v: 8'hA0};

    // Eight vertical bars, left to right: white, yellow, cyan, green,
    // magenta, red, blue, black
    function automatic yuv_t bar_yuv(input logic [2:0] idx);
        yuv_t r;
        case (idx)
            3'd0:    r = '{y: 8'hEB, u: 8'h80, v: 8'h80};
            3'd1:    r = '{y: 8'hD2, u: 8'h10, v: 8'h92};
            3'd2:    r = '{y: 8'hAA, u: 8'hA6, v: 8'h10};
            3'd3:    r = '{y: 8'h91, u: 8'h36, v: 8'h22};
            3'd4:    r = '{y: 8'h6A, u: 8'hCA, v: 8'hDE};
            3'd5:    r = '{y: 8'h51, u: 8'h5A, v: 8'hF0};
            3'd6:    r = '{y: 8'h29, u: 8'hF0, v: 8'h6E};
            default: r = '{y: 8'h10, u: 8'h80, v: 8'h80};
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ov_stream_gen_pixel.sv
`default_nettype none
// ============================================================================
//  Module   : ov_stream_gen_pixel
//  Purpose  : Combinational test-image generator. Maps a pixel coordinate and
//             the frame's latched pattern / blob settings to a YUV colour.
//  Revision : 1.0 - initial release
// ============================================================================
module ov_stream_gen_pixel
    import ov_stream_gen_pkg::*;
#(
    parameter int H_ACTIVE = c_CAM_WIDTH
) (
    input  logic [9:0] x,
    input  logic [8:0] y,
    input  logic [1:0] pattern,
    input  logic [9:0] blob_x,
    input  logic [8:0] blob_y,
    input  logic [9:0] blob_w,
    input  logic [8:0] blob_h,
    output yuv_t       pix
);

    localparam int unsigned c_BAR_W = H_ACTIVE / 8;

    logic [10:0] w_x_end;
    logic [10:0] w_y_end;
    logic        w_hit;
    logic        w_bars_on;
    logic        w_blob_on;
    logic [2:0]  w_bar_idx;

    // 11-bit end coordinates so a blob running past the edge never wraps
    assign w_x_end   = {1'b0, blob_x} + {1'b0, blob_w};
    assign w_y_end   = {2'b00, blob_y} + {2'b00, blob_h};
    assign w_hit     = (x >= blob_x) && ({1'b0, x} < w_x_end) &&
                       (y >= blob_y) && ({2'b00, y} < w_y_end);
    assign w_bars_on = (pattern == c_PAT_BARS) || (pattern == c_PAT_BOTH);
    assign w_blob_on = (pattern == c_PAT_BLOB) || (pattern == c_PAT_BOTH);
    assign w_bar_idx = 3'(32'(x) / c_BAR_W);

    // Background, optionally overlaid with bars, with the blob on top
    always_comb begin
        pix = c_YUV_BG;
        if (w_bars_on) begin
            pix = bar_yuv(w_bar_idx);
        end
        if (w_blob_on && w_hit) begin
            pix = c_YUV_SKIN;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ov_stream_gen.sv
`default_nettype none
// ============================================================================
//  Module   : ov_stream_gen
//  Purpose  : OV7670-style YUV422 pixel stream source. Generates ov_pclk
//             (clk/2), vsync, href and the byte stream for selectable test
//             images, standing in for the physical camera.
//  Revision : 1.0 - initial release
// ============================================================================
module ov_stream_gen
    import ov_stream_gen_pkg::*;
#(
    parameter int H_ACTIVE = c_CAM_WIDTH,
    parameter int H_TOTAL  = c_H_TOTAL,
    parameter int V_SYNC   = c_V_SYNC,
    parameter int V_BACK   = c_V_BACK,
    parameter int V_ACTIVE = c_CAM_HEIGHT,
    parameter int V_FRONT  = c_V_FRONT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [9:0]  blob_x,
    input  logic [8:0]  blob_y,
    input  logic [9:0]  blob_w,
    input  logic [8:0]  blob_h,
    output logic        ov_pclk,
    output logic        ov_vs,
    output logic        ov_hs,
    output logic [7:0]  cam_data,
    output logic        busy,
    output logic [15:0] frame_cnt
);

    localparam int c_BW = $clog2(H_TOTAL);

    logic              r_pclk;
    logic [c_ST_W-1:0] r_state;
    logic [c_ST_W-1:0] w_state_nxt;
    logic [c_BW-1:0]   r_byte;
    logic [c_BW-1:0]   w_byte_nxt;
    logic [8:0]        r_line;
    logic [8:0]        w_line_nxt;
    logic              w_tick;
    logic              w_pclk_run;
    logic              w_line_end;
    logic              w_phase_last;
    logic              w_phase_end;
    logic              w_frame_start;
    logic              w_frame_done;
    logic [1:0]        r_pat;
    logic [9:0]        r_blob_x;
    logic [8:0]        r_blob_y;
    logic [9:0]        r_blob_w;
    logic [8:0]        r_blob_h;
    logic [9:0]        w_px_x;
    yuv_t              w_pix;
    logic              w_vs_nxt;
    logic              w_hs_nxt;
    logic [7:0]        w_data_nxt;
    logic              r_vs;
    logic              r_hs;
    logic [7:0]        r_data;
    logic [15:0]       r_frame_cnt;

    // Stream state advances on the clk edge where pclk falls (pclk high now);
    // pclk only runs while a frame is active or requested, and always
    // completes a high phase
    assign w_tick     = r_pclk;
    assign w_pclk_run = (r_state != c_ST_IDLE) || enable || r_pclk;

    assign w_line_end  = (r_byte == c_BW'(H_TOTAL - 1));
    assign w_phase_end = w_line_end && w_phase_last;

    // Pixel clock divider
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pclk <= 1'b0;
        end else if (w_pclk_run) begin
            r_pclk <= ~r_pclk;
        end
    end

    // Last line of the current vertical phase
    always_comb begin
        w_phase_last = 1'b0;
        case (r_state)
            c_ST_VSYNC:  w_phase_last = (r_line == 9'(V_SYNC - 1));
            c_ST_VBACK:  w_phase_last = (r_line == 9'(V_BACK - 1));
            c_ST_ACTIVE: w_phase_last = (r_line == 9'(V_ACTIVE - 1));
            c_ST_VFRONT: w_phase_last = (r_line == 9'(V_FRONT - 1));
            default:     w_phase_last = 1'b0;
        endcase
    end

    // Next-state logic for the frame FSM
    always_comb begin
        w_state_nxt = r_state;
        if (w_tick) begin
            case (r_state)
                c_ST_IDLE:   if (enable)      w_state_nxt = c_ST_VSYNC;
                c_ST_VSYNC:  if (w_phase_end) w_state_nxt = c_ST_VBACK;
                c_ST_VBACK:  if (w_phase_end) w_state_nxt = c_ST_ACTIVE;
                c_ST_ACTIVE: if (w_phase_end) w_state_nxt = c_ST_VFRONT;
                c_ST_VFRONT: if (w_phase_end) w_state_nxt = enable ? c_ST_VSYNC : c_ST_IDLE;
                default:                      w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    // Next byte / line counters; both stay at zero while idle
    always_comb begin
        w_byte_nxt = r_byte;
        w_line_nxt = r_line;
        if (w_tick && (r_state != c_ST_IDLE)) begin
            if (w_line_end) begin
                w_byte_nxt = '0;
                w_line_nxt = w_phase_last ? 9'd0 : r_line + 9'd1;
            end else begin
                w_byte_nxt = r_byte + c_BW'(1);
            end
        end
    end

    assign w_frame_start = w_tick && (w_state_nxt == c_ST_VSYNC) && (r_state != c_ST_VSYNC);
    assign w_frame_done  = w_tick && (r_state == c_ST_VFRONT) && w_phase_end;

    // State and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_byte  <= '0;
            r_line  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_byte  <= w_byte_nxt;
            r_line  <= w_line_nxt;
        end
    end

    // Image settings are captured once per frame so a frame never tears
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pat    <= '0;
            r_blob_x <= '0;
            r_blob_y <= '0;
            r_blob_w <= '0;
            r_blob_h <= '0;
        end else if (w_frame_start) begin
            r_pat    <= pattern_sel;
            r_blob_x <= blob_x;
            r_blob_y <= blob_y;
            r_blob_w <= blob_w;
            r_blob_h <= blob_h;
        end
    end

    // Completed-frame counter, wraps naturally at 16 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt <= '0;
        end else if (w_frame_done) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    // U and V bytes (b[1:0] = 0, 2) take the even pixel of the pair
    assign w_px_x = 10'({w_byte_nxt[c_BW-1:2], w_byte_nxt[1] & w_byte_nxt[0]});

    ov_stream_gen_pixel #(
        .H_ACTIVE (H_ACTIVE)
    ) u_pixel (
        .x       (w_px_x),
        .y       (w_line_nxt),
        .pattern (r_pat),
        .blob_x  (r_blob_x),
        .blob_y  (r_blob_y),
        .blob_w  (r_blob_w),
        .blob_h  (r_blob_h),
        .pix     (w_pix)
    );

    // Output decode from the upcoming state so the registers line up with it
    always_comb begin
        w_vs_nxt   = (w_state_nxt == c_ST_VSYNC);
        w_hs_nxt   = (w_state_nxt == c_ST_ACTIVE) && (w_byte_nxt < c_BW'(2 * H_ACTIVE));
        w_data_nxt = 8'h00;
        if (w_hs_nxt) begin
            case (w_byte_nxt[1:0])
                2'd0:    w_data_nxt = w_pix.u;
                2'd2:    w_data_nxt = w_pix.v;
                default: w_data_nxt = w_pix.y;
            endcase
        end
        busy = (r_state != c_ST_IDLE);
    end

    // Stream output registers, updated only on pclk falling edges
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vs   <= 1'b0;
            r_hs   <= 1'b0;
            r_data <= 8'h00;
        end else if (w_tick) begin
            r_vs   <= w_vs_nxt;
            r_hs   <= w_hs_nxt;
            r_data <= w_data_nxt;
        end
    end

    assign ov_pclk   = r_pclk;
    assign ov_vs     = r_vs;
    assign ov_hs     = r_hs;
    assign cam_data  = r_data;
    assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ov_stream_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ov_stream_gen
//  Purpose  : Self-checking bench for ov_stream_gen with reduced timing.
//             A frame-position reference model predicts every pclk period;
//             a vector table checks captured image bytes for fixed settings.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ov_stream_gen;

    localparam int HA    = 16;
    localparam int HT    = 40;
    localparam int VS    = 2;
    localparam int VB    = 1;
    localparam int VA    = 6;
    localparam int VF    = 1;
    localparam int FRAME = (VS + VB + VA + VF) * HT;

    localparam logic [23:0] BAR_TAB [8] = '{24'hEB8080, 24'hD21092, 24'hAAA610, 24'h913622,
                                             24'h6ACADE, 24'h515AF0, 24'h29F06E, 24'h108080};

    typedef struct {
        int pat;
        int bx;
        int by;
        int bw;
        int bh;
    } cfg_t;

    typedef struct {
        int         ci;
        int         y;
        int         b;
        logic [7:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable = 1'b0;
    logic [1:0]  pattern_sel = '0;
    logic [9:0]  blob_x = '0;
    logic [8:0]  blob_y = '0;
    logic [9:0]  blob_w = '0;
    logic [8:0]  blob_h = '0;
    logic        ov_pclk;
    logic        ov_vs;
    logic        ov_hs;
    logic [7:0]  cam_data;
    logic        busy;
    logic [15:0] frame_cnt;

    int total = 0;
    int bad   = 0;

    ov_stream_gen #(
        .H_ACTIVE (HA), .H_TOTAL (HT), .V_SYNC (VS),
        .V_BACK   (VB), .V_ACTIVE (VA), .V_FRONT (VF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .pattern_sel (pattern_sel),
        .blob_x      (blob_x),
        .blob_y      (blob_y),
        .blob_w      (blob_w),
        .blob_h      (blob_h),
        .ov_pclk     (ov_pclk),
        .ov_vs       (ov_vs),
        .ov_hs       (ov_hs),
        .cam_data    (cam_data),
        .busy        (busy),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // m_pos is the pclk period index inside the current frame (-1 = idle)
    bit   m_pclk   = 1'b0;
    int   m_pos    = -1;
    int   m_frames = 0;
    cfg_t m_cfg    = '{0, 0, 0, 0, 0};

    function automatic cfg_t cur_cfg();
        cfg_t c;
        c.pat = int'(pattern_sel);
        c.bx  = int'(blob_x);
        c.by  = int'(blob_y);
        c.bw  = int'(blob_w);
        c.bh  = int'(blob_h);
        return c;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pclk   <= 1'b0;
            m_pos    <= -1;
            m_frames <= 0;
        end else begin
            if (m_pos >= 0 || enable || m_pclk) m_pclk <= !m_pclk;
            if (m_pclk) begin
                if (m_pos < 0) begin
                    if (enable) begin
                        m_pos <= 0;
                        m_cfg <= cur_cfg();
                    end
                end else if (m_pos == FRAME - 1) begin
                    m_frames <= (m_frames + 1) % 65536;
                    if (enable) begin
                        m_pos <= 0;
                        m_cfg <= cur_cfg();
                    end else begin
                        m_pos <= -1;
                    end
                end else begin
                    m_pos <= m_pos + 1;
                end
            end
        end
    end

    function automatic logic [23:0] colour(input cfg_t c, input int x, input int y);
        logic [23:0] r;
        r = 24'h208080;
        if (c.pat == 1 || c.pat == 3) r = BAR_TAB[x / (HA / 8)];
        if ((c.pat == 2 || c.pat == 3) && x >= c.bx && x < c.bx + c.bw &&
            y >= c.by && y < c.by + c.bh) r = 24'h8070A0;
        return r;
    endfunction

    function automatic void exp_out(input int pos, input cfg_t c,
                                    output logic vs, output logic hs, output logic [7:0] d);
        int line, b, act, xe;
        logic [23:0] col;
        vs = 1'b0; hs = 1'b0; d = 8'h00;
        if (pos >= 0) begin
            line = pos / HT;
            b    = pos % HT;
            act  = line - VS - VB;
            vs   = (line < VS);
            if (act >= 0 && act < VA && b < 2 * HA) begin
                hs  = 1'b1;
                xe  = (b / 4) * 2;
                col = colour(c, (b % 4 == 3) ? xe + 1 : xe, act);
                case (b % 4)
                    0:       d = col[15:8];
                    2:       d = col[7:0];
                    default: d = col[23:16];
                endcase
            end
        end
    endfunction

    // ---------------- monitor state ----------------
    logic [7:0] cap [VA][2*HA];
    int cap_line, cap_b, hs_run, prev_hs;
    int vs_clk, hs_pulses, hs_min, hs_max, busy_clk, pclk_edges, prev_pclk;

    task automatic clear_stats();
        vs_clk = 0; hs_pulses = 0; hs_min = 1000; hs_max = 0;
        busy_clk = 0; pclk_edges = 0;
    endtask

    task automatic check(input string name, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // One clk period: compare the full output set against the model, update stats
    task automatic tick();
        logic evs, ehs;
        logic [7:0] ed;
        @(negedge clk);
        exp_out(m_pos, m_cfg, evs, ehs, ed);
        total++;
        if ({ov_pclk, ov_vs, ov_hs, cam_data, busy, frame_cnt} !==
            {m_pclk, evs, ehs, ed, (m_pos >= 0), 16'(m_frames)}) begin
            bad++;
            $display("FAIL stream t=%0t: got pclk=%b vs=%b hs=%b data=%02h busy=%b fcnt=%0d; expected pclk=%b vs=%b hs=%b data=%02h busy=%b fcnt=%0d",
                     $time, ov_pclk, ov_vs, ov_hs, cam_data, busy, frame_cnt,
                     m_pclk, evs, ehs, ed, (m_pos >= 0), m_frames);
        end
        if (ov_vs === 1'b1) vs_clk++;
        if (busy === 1'b1) busy_clk++;
        if (ov_pclk !== prev_pclk) pclk_edges++;
        prev_pclk = ov_pclk;
        if (ov_pclk === 1'b1) begin
            if (ov_vs === 1'b1) begin
                cap_line = 0; cap_b = 0;
            end
            if (ov_hs === 1'b1) begin
                if (prev_hs == 0) hs_pulses++;
                if (cap_line < VA && cap_b < 2 * HA) cap[cap_line][cap_b] = cam_data;
                cap_b++;
                hs_run++;
            end else if (prev_hs != 0) begin
                if (hs_run < hs_min) hs_min = hs_run;
                if (hs_run > hs_max) hs_max = hs_run;
                hs_run = 0; cap_line++; cap_b = 0;
            end
            prev_hs = (ov_hs === 1'b1) ? 1 : 0;
        end
    endtask

    task automatic drive_cfg(input cfg_t c);
        pattern_sel = 2'(c.pat);
        blob_x = 10'(c.bx); blob_y = 9'(c.by);
        blob_w = 10'(c.bw); blob_h = 9'(c.bh);
    endtask

    task automatic wait_busy(input logic val, input int budget, input string name);
        int n = 0;
        while (busy !== val && n < budget) begin
            tick();
            n++;
        end
        check(name, busy, val);
    endtask

    task automatic rand_cfg();
        cfg_t c;
        c.pat = $urandom_range(0, 3);
        c.bx  = $urandom_range(0, 15);
        c.by  = $urandom_range(0, 5);
        c.bw  = $urandom_range(0, 10);
        c.bh  = $urandom_range(0, 4);
        if ($urandom_range(0, 7) == 0) c.bx = 1020;
        drive_cfg(c);
    endtask

    cfg_t cfgs [4];
    vec_t vecs [$];

    initial begin
        int base, n;
        cap_line = 0; cap_b = 0; hs_run = 0; prev_hs = 0; prev_pclk = 0;
        clear_stats();

        cfgs[0] = '{0, 0, 0, 0, 0};
        cfgs[1] = '{1, 0, 0, 0, 0};
        cfgs[2] = '{2, 3, 2, 4, 2};
        cfgs[3] = '{3, 14, 5, 10, 10};

        vecs.push_back('{0, 0, 0, 8'h80});  vecs.push_back('{0, 0, 1, 8'h20});
        vecs.push_back('{0, 0, 2, 8'h80});  vecs.push_back('{0, 5, 31, 8'h20});
        vecs.push_back('{1, 0, 0, 8'h80});  vecs.push_back('{1, 0, 1, 8'hEB});
        vecs.push_back('{1, 0, 4, 8'h10});  vecs.push_back('{1, 0, 5, 8'hD2});
        vecs.push_back('{1, 3, 6, 8'h92});  vecs.push_back('{1, 3, 7, 8'hD2});
        vecs.push_back('{1, 4, 8, 8'hA6});  vecs.push_back('{1, 5, 29, 8'h10});
        vecs.push_back('{2, 2, 4, 8'h80});  vecs.push_back('{2, 2, 5, 8'h20});
        vecs.push_back('{2, 2, 6, 8'h80});  vecs.push_back('{2, 2, 7, 8'h80});
        vecs.push_back('{2, 2, 8, 8'h70});  vecs.push_back('{2, 3, 10, 8'hA0});
        vecs.push_back('{2, 3, 12, 8'h70}); vecs.push_back('{2, 3, 15, 8'h20});
        vecs.push_back('{2, 4, 9, 8'h20});  vecs.push_back('{2, 1, 13, 8'h20});
        vecs.push_back('{3, 5, 28, 8'h70}); vecs.push_back('{3, 5, 29, 8'h80});
        vecs.push_back('{3, 5, 31, 8'h80}); vecs.push_back('{3, 4, 28, 8'h80});
        vecs.push_back('{3, 4, 29, 8'h10}); vecs.push_back('{3, 0, 5, 8'hD2});

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        check("reset_outputs", {ov_pclk, ov_vs, ov_hs, cam_data, busy, frame_cnt}, 0);
        rst = 1'b0;
        repeat (4) tick();
        check("idle_no_pclk", ov_pclk, 0);

        // Single frames with fixed images, checked against the byte table
        for (int ci = 0; ci < 4; ci++) begin
            base = frame_cnt;
            drive_cfg(cfgs[ci]);
            clear_stats();
            enable = 1'b1;
            wait_busy(1'b1, 10, "frame_start");
            enable = 1'b0;
            wait_busy(1'b0, FRAME * 2 + 20, "frame_end");
            check("frame_cnt_inc", frame_cnt, 16'(base + 1));
            check("vs_clk_len", vs_clk, VS * HT * 2);
            check("hs_pulses", hs_pulses, VA);
            check("hs_len_min", hs_min, 2 * HA);
            check("hs_len_max", hs_max, 2 * HA);
            check("busy_clk_len", busy_clk, FRAME * 2);
            foreach (vecs[i]) begin
                if (vecs[i].ci == ci) check($sformatf("img%0d_y%0d_b%0d", ci, vecs[i].y, vecs[i].b),
                                            cap[vecs[i].y][vecs[i].b], vecs[i].exp);
            end
        end

        // Reset in the middle of active video, released with enable low
        drive_cfg(cfgs[1]);
        enable = 1'b1;
        n = 0;
        while (ov_hs !== 1'b1 && n < FRAME * 2) begin tick(); n++; end
        check("reached_active", ov_hs, 1);
        rst = 1'b1;
        enable = 1'b0;
        tick();
        check("midframe_reset", {ov_pclk, ov_vs, ov_hs, cam_data, busy, frame_cnt}, 0);
        tick();
        rst = 1'b0;
        clear_stats();
        repeat (60) tick();
        check("post_reset_pclk_edges", pclk_edges, 0);
        check("post_reset_busy", busy_clk, 0);
        check("post_reset_fcnt", frame_cnt, 0);

        // Back-to-back frames with settings changing mid-frame
        base = frame_cnt;
        clear_stats();
        enable = 1'b1;
        n = 0;
        while (frame_cnt !== 16'(base + 3) && n < FRAME * 8) begin
            tick();
            n++;
            if (n % 211 == 0) rand_cfg();
        end
        check("three_frames", frame_cnt, 16'(base + 3));
        check("three_frames_hs", hs_pulses, 3 * VA);
        check("no_gap_busy", busy, 1);
        enable = 1'b0;
        wait_busy(1'b0, FRAME * 2 + 20, "b2b_end");
        check("b2b_fcnt", frame_cnt, 16'(base + 4));

        // Enable dropped during active line 3, pattern changed mid-frame
        base = frame_cnt;
        drive_cfg(cfgs[2]);
        clear_stats();
        enable = 1'b1;
        wait_busy(1'b1, 10, "drop_start");
        n = 0;
        while (hs_pulses < 3 && n < FRAME * 2) begin tick(); n++; end
        enable = 1'b0;
        drive_cfg(cfgs[3]);
        wait_busy(1'b0, FRAME * 2 + 20, "drop_end");
        check("drop_fcnt", frame_cnt, 16'(base + 1));
        check("drop_full_frame", hs_pulses, VA);
        check("drop_img_kept", cap[3][8], 8'h70);
        clear_stats();
        repeat (300) tick();
        check("drop_no_more_vs", vs_clk, 0);
        check("drop_stays_idle", busy_clk, 0);

        // Randomized runs, including enable pulses too short to start a frame
        for (int it = 0; it < 6; it++) begin
            rand_cfg();
            if (it % 2 == 1) begin
                enable = 1'b1;
                tick();
                enable = 1'b0;
                repeat (5) tick();
                check("short_enable_idle", busy, 0);
            end
            enable = 1'b1;
            repeat ($urandom_range(2, 1000)) begin
                tick();
                if ($urandom_range(0, 99) == 0) rand_cfg();
            end
            enable = 1'b0;
            rand_cfg();
            wait_busy(1'b0, FRAME * 2 + 20, "rand_end");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
